// File: rtl/insn_sequencer.sv
// Brainfuck execution controller: fetches an instruction from the IP line, decodes it and
// dispatches one operation to the AP counter, data counter or I/O port, then retires it.
module insn_sequencer #(
    parameter int unsigned INSN_WIDTH = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Run,
    input  logic                  Step,
    output logic                  IpRequest,
    input  logic                  IpReady,
    output logic                  IpHaltRq,
    input  logic [INSN_WIDTH-1:0] Insn,
    output logic                  DataIsZeroed,
    output logic                  ApRequest,
    output logic                  ApDec,
    input  logic                  ApReady,
    output logic                  DataRequest,
    output logic                  DataDec,
    input  logic                  DataReady,
    input  logic                  DataZero,
    output logic                  IoOutRequest,
    input  logic                  IoOutReady,
    output logic                  IoInRequest,
    input  logic                  IoInReady,
    output logic                  Busy,
    output logic                  Halted,
    output logic [CNT_WIDTH-1:0]  InsnCount
);

    localparam logic [INSN_WIDTH-1:0] OpHalt  = INSN_WIDTH'(1);
    localparam logic [INSN_WIDTH-1:0] OpInc   = INSN_WIDTH'(2);
    localparam logic [INSN_WIDTH-1:0] OpDec   = INSN_WIDTH'(3);
    localparam logic [INSN_WIDTH-1:0] OpRight = INSN_WIDTH'(4);
    localparam logic [INSN_WIDTH-1:0] OpLeft  = INSN_WIDTH'(5);
    localparam logic [INSN_WIDTH-1:0] OpOut   = INSN_WIDTH'(8);
    localparam logic [INSN_WIDTH-1:0] OpIn    = INSN_WIDTH'(9);

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StFetchWait,
        StDecode,
        StExecAp,
        StExecData,
        StExecOut,
        StExecIn,
        StDone,
        StHalted
    } state_e;

    state_e                state_q, state_d;
    logic [INSN_WIDTH-1:0] insn_q, insn_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  zero_q, zero_d;
    logic                  issued_q, issued_d;
    logic                  ip_req_q, ip_req_d;
    logic                  ap_req_q, ap_req_d;
    logic                  ap_dec_q, ap_dec_d;
    logic                  data_req_q, data_req_d;
    logic                  data_dec_q, data_dec_d;
    logic                  out_req_q, out_req_d;
    logic                  in_req_q, in_req_d;

    // A request pulse being high doubles as the wait flag: Ready is ignored in that cycle.
    always_comb begin
        state_d    = state_q;
        insn_d     = insn_q;
        cnt_d      = cnt_q;
        zero_d     = zero_q;
        issued_d   = issued_q;
        ip_req_d   = 1'b0;
        ap_req_d   = 1'b0;
        ap_dec_d   = ap_dec_q;
        data_req_d = 1'b0;
        data_dec_d = data_dec_q;
        out_req_d  = 1'b0;
        in_req_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Run || Step) state_d = StFetch;
            end
            StFetch: begin
                if (IpReady) begin
                    ip_req_d = 1'b1;
                    state_d  = StFetchWait;
                end
            end
            StFetchWait: begin
                if (IpReady && !ip_req_q) begin
                    insn_d  = Insn;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                issued_d = 1'b0;
                case (insn_q)
                    OpInc, OpDec:   state_d = StExecData;
                    OpRight, OpLeft: state_d = StExecAp;
                    OpOut: begin
                        out_req_d = 1'b1;
                        state_d   = StExecOut;
                    end
                    OpIn: begin
                        in_req_d = 1'b1;
                        state_d  = StExecIn;
                    end
                    OpHalt:  state_d = StHalted;
                    default: state_d = StDone;
                endcase
            end
            StExecAp: begin
                if (!issued_q) begin
                    if (ApReady) begin
                        ap_req_d = 1'b1;
                        ap_dec_d = (insn_q == OpLeft);
                        issued_d = 1'b1;
                    end
                end else if (ApReady && !ap_req_q) begin
                    state_d = StDone;
                end
            end
            StExecData: begin
                if (!issued_q) begin
                    if (DataReady) begin
                        data_req_d = 1'b1;
                        data_dec_d = (insn_q == OpDec);
                        issued_d   = 1'b1;
                    end
                end else if (DataReady && !data_req_q) begin
                    state_d = StDone;
                end
            end
            StExecOut: begin
                if (IoOutReady) state_d = StDone;
            end
            StExecIn: begin
                if (IoInReady) state_d = StDone;
            end
            StDone: begin
                cnt_d   = cnt_q + 1'b1;
                zero_d  = DataZero;
                state_d = Run ? StFetch : StIdle;
            end
            StHalted: begin
                if (!Run && !Step) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q    <= StIdle;
            insn_q     <= '0;
            cnt_q      <= '0;
            zero_q     <= 1'b1;
            issued_q   <= 1'b0;
            ip_req_q   <= 1'b0;
            ap_req_q   <= 1'b0;
            ap_dec_q   <= 1'b0;
            data_req_q <= 1'b0;
            data_dec_q <= 1'b0;
            out_req_q  <= 1'b0;
            in_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            insn_q     <= insn_d;
            cnt_q      <= cnt_d;
            zero_q     <= zero_d;
            issued_q   <= issued_d;
            ip_req_q   <= ip_req_d;
            ap_req_q   <= ap_req_d;
            ap_dec_q   <= ap_dec_d;
            data_req_q <= data_req_d;
            data_dec_q <= data_dec_d;
            out_req_q  <= out_req_d;
            in_req_q   <= in_req_d;
        end
    end

    assign IpRequest    = ip_req_q;
    assign IpHaltRq     = (state_q == StHalted);
    assign Halted       = (state_q == StHalted);
    assign Busy         = (state_q != StIdle) && (state_q != StHalted);
    assign DataIsZeroed = zero_q;
    assign ApRequest    = ap_req_q;
    assign ApDec        = ap_dec_q;
    assign DataRequest  = data_req_q;
    assign DataDec      = data_dec_q;
    assign IoOutRequest = out_req_q;
    assign IoInRequest  = in_req_q;
    assign InsnCount    = cnt_q;

endmodule

// File: tb/tb_insn_sequencer.sv
// Directed bench for insn_sequencer with small behavioural models of the IP line, AP and
// data counters and the I/O port.
module tb_insn_sequencer;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Run = 1'b0;
    logic        Step = 1'b0;
    logic        IpRequest, IpHaltRq, DataIsZeroed, ApRequest, ApDec, DataRequest, DataDec;
    logic        IoOutRequest, IoInRequest, Busy, Halted;
    logic        IpReady, ApReady, DataReady, DataZero, IoOutReady, IoInReady;
    logic [3:0]  Insn;
    logic [15:0] InsnCount;

    int n_cmp = 0;
    int n_err = 0;

    // Model configuration (written by tasks only)
    logic [3:0] prog[$];
    int lat = 4;
    int out_lat = 2;
    int in_lat = 10;

    // Model state (written by the model process only)
    int pc, ip_cd, ap_cd, data_cd, out_cd, in_cd, ap_ptr;
    logic [7:0] cells[8];

    // Monitor logs (written by the monitor process only)
    int evt_q[$];   // 1 data+, 2 data-, 3 ap+, 4 ap-, 5 out, 6 in
    logic zflag_q[$];
    int ip_cnt = 0;

    insn_sequencer #(.INSN_WIDTH(4), .CNT_WIDTH(16)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .Step(Step),
        .IpRequest(IpRequest), .IpReady(IpReady), .IpHaltRq(IpHaltRq), .Insn(Insn),
        .DataIsZeroed(DataIsZeroed),
        .ApRequest(ApRequest), .ApDec(ApDec), .ApReady(ApReady),
        .DataRequest(DataRequest), .DataDec(DataDec), .DataReady(DataReady),
        .DataZero(DataZero),
        .IoOutRequest(IoOutRequest), .IoOutReady(IoOutReady),
        .IoInRequest(IoInRequest), .IoInReady(IoInReady),
        .Busy(Busy), .Halted(Halted), .InsnCount(InsnCount)
    );

    always #5 Clk = ~Clk;

    // Datapath models react on the falling edge so the DUT sees stable inputs.
    always @(negedge Clk) begin
        if (!Rst_n) begin
            pc = 0; ip_cd = 0; ap_cd = 0; data_cd = 0; out_cd = 0; in_cd = 0; ap_ptr = 0;
            for (int i = 0; i < 8; i++) cells[i] = 8'd0;
            IpReady = 1'b1; ApReady = 1'b1; DataReady = 1'b1; DataZero = 1'b1;
            IoOutReady = 1'b0; IoInReady = 1'b0; Insn = 4'd0;
        end else begin
            if (IpRequest) begin
                IpReady = 1'b0; ip_cd = lat;
            end else if (!IpReady) begin
                if (ip_cd > 1) ip_cd--;
                else begin
                    IpReady = 1'b1;
                    Insn = (pc < prog.size()) ? prog[pc] : 4'd1;
                    pc++;
                end
            end
            if (ApRequest) begin
                ApReady = 1'b0; ap_cd = lat;
                ap_ptr = ApDec ? ((ap_ptr + 7) % 8) : ((ap_ptr + 1) % 8);
            end else if (!ApReady) begin
                if (ap_cd > 1) ap_cd--;
                else ApReady = 1'b1;
            end
            if (DataRequest) begin
                DataReady = 1'b0; data_cd = lat;
                cells[ap_ptr] = DataDec ? cells[ap_ptr] - 8'd1 : cells[ap_ptr] + 8'd1;
            end else if (!DataReady) begin
                if (data_cd > 1) data_cd--;
                else DataReady = 1'b1;
            end
            DataZero = (cells[ap_ptr] == 8'd0);
            IoOutReady = 1'b0;
            if (IoOutRequest) out_cd = out_lat;
            else if (out_cd != 0) begin
                out_cd--;
                if (out_cd == 0) IoOutReady = 1'b1;
            end
            IoInReady = 1'b0;
            if (IoInRequest) in_cd = in_lat;
            else if (in_cd != 0) begin
                in_cd--;
                if (in_cd == 0) IoInReady = 1'b1;
            end
        end
    end

    always @(negedge Clk) begin
        if (Rst_n) begin
            if (IpRequest) begin ip_cnt++; zflag_q.push_back(DataIsZeroed); end
            if (DataRequest) evt_q.push_back(DataDec ? 2 : 1);
            if (ApRequest) evt_q.push_back(ApDec ? 4 : 3);
            if (IoOutRequest) evt_q.push_back(5);
            if (IoInRequest) evt_q.push_back(6);
        end
    end

    task automatic apply_reset();
        @(negedge Clk);
        Run = 1'b0; Step = 1'b0; Rst_n = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic pulse_step();
        @(negedge Clk); Step = 1'b1;
        @(negedge Clk); Step = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge Clk);
            if (!Busy) break;
        end
        n_cmp++;
        if (Busy !== 1'b0) begin
            n_err++; $display("FAIL %s idle timeout: Busy=%b required 0", name, Busy);
        end
    endtask

    task automatic wait_halted(input string name);
        int k;
        for (k = 0; k < 600; k++) begin
            @(negedge Clk);
            if (Halted) break;
        end
        n_cmp++;
        if (Halted !== 1'b1) begin
            n_err++; $display("FAIL %s halt timeout: Halted=%b required 1", name, Halted);
        end
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Rst_n = 1'b0; Run = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n_cmp++;
        if ({IpRequest, ApRequest, DataRequest, IoOutRequest, IoInRequest} !== 5'b0) begin
            n_err++; $display("FAIL reset_req: got %b required 00000",
                {IpRequest, ApRequest, DataRequest, IoOutRequest, IoInRequest});
        end
        n_cmp++;
        if ({ApDec, DataDec, IpHaltRq, Busy, Halted} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctl: got %b required 00000",
                {ApDec, DataDec, IpHaltRq, Busy, Halted});
        end
        n_cmp++;
        if (InsnCount !== 16'd0) begin
            n_err++; $display("FAIL reset_cnt: got %0d required 0", InsnCount);
        end
        n_cmp++;
        if (DataIsZeroed !== 1'b1) begin
            n_err++; $display("FAIL reset_zero: got %b required 1", DataIsZeroed);
        end
        prog = '{4'd0};
        Rst_n = 1'b1;
        @(negedge Clk);
        n_cmp++;
        if (IpRequest !== 1'b0 || Busy !== 1'b1) begin
            n_err++; $display("FAIL reset_first_edge: IpRequest=%b Busy=%b required 0 1",
                IpRequest, Busy);
        end
        @(negedge Clk);
        n_cmp++;
        if (IpRequest !== 1'b1) begin
            n_err++; $display("FAIL reset_fetch_latency: IpRequest=%b required 1", IpRequest);
        end
    endtask

    task automatic test_run_program();
        int base;
        apply_reset();
        base = evt_q.size();
        prog = '{4'd2, 4'd2, 4'd4, 4'd3, 4'd1};
        Run = 1'b1;
        wait_halted("run_program");
        Run = 1'b0;
        @(negedge Clk);
        n_cmp++;
        if (evt_q.size() - base != 4) begin
            n_err++; $display("FAIL run_evt_count: got %0d required 4", evt_q.size() - base);
        end else begin
            n_cmp++;
            if (evt_q[base] != 1 || evt_q[base+1] != 1 || evt_q[base+2] != 3
                || evt_q[base+3] != 2) begin
                n_err++; $display("FAIL run_evt_order: got %0d %0d %0d %0d required 1 1 3 2",
                    evt_q[base], evt_q[base+1], evt_q[base+2], evt_q[base+3]);
            end
        end
        n_cmp++;
        if (InsnCount !== 16'd4) begin
            n_err++; $display("FAIL run_cnt: got %0d required 4", InsnCount);
        end
        n_cmp++;
        if (DataDec !== 1'b1 || ApDec !== 1'b0) begin
            n_err++; $display("FAIL run_dec_hold: DataDec=%b ApDec=%b required 1 0",
                DataDec, ApDec);
        end
    endtask

    task automatic test_step();
        int base, ipb, k;
        apply_reset();
        base = evt_q.size(); ipb = ip_cnt;
        prog = '{4'd5, 4'd2, 4'd2};
        pulse_step();
        for (k = 0; k < 20 && !Busy; k++) @(negedge Clk);
        pulse_step();   // ignored while busy
        wait_idle("step");
        repeat (20) @(negedge Clk);
        n_cmp++;
        if (evt_q.size() - base != 1 || evt_q[base] != 4) begin
            n_err++; $display("FAIL step_evt: count=%0d first=%0d required 1 event of 4",
                evt_q.size() - base, (evt_q.size() > base) ? evt_q[base] : -1);
        end
        n_cmp++;
        if (ip_cnt - ipb != 1) begin
            n_err++; $display("FAIL step_fetches: got %0d required 1", ip_cnt - ipb);
        end
        n_cmp++;
        if (InsnCount !== 16'd1 || ApDec !== 1'b1 || Busy !== 1'b0) begin
            n_err++; $display("FAIL step_state: cnt=%0d ApDec=%b Busy=%b required 1 1 0",
                InsnCount, ApDec, Busy);
        end
    endtask

    task automatic test_loop_flag();
        int base, zb;
        apply_reset();
        base = evt_q.size(); zb = zflag_q.size();
        prog = '{4'd2, 4'd7, 4'd3, 4'd6, 4'd1};
        Run = 1'b1;
        wait_halted("loop_flag");
        Run = 1'b0;
        @(negedge Clk);
        n_cmp++;
        if (zflag_q.size() - zb != 5) begin
            n_err++; $display("FAIL loop_fetches: got %0d required 5", zflag_q.size() - zb);
        end else begin
            n_cmp++;
            if ({zflag_q[zb], zflag_q[zb+1], zflag_q[zb+2], zflag_q[zb+3], zflag_q[zb+4]}
                !== 5'b10011) begin
                n_err++; $display("FAIL loop_zero_flags: got %b required 10011",
                    {zflag_q[zb], zflag_q[zb+1], zflag_q[zb+2], zflag_q[zb+3],
                     zflag_q[zb+4]});
            end
        end
        n_cmp++;
        if (evt_q.size() - base != 2) begin
            n_err++; $display("FAIL loop_evt_count: got %0d required 2", evt_q.size() - base);
        end
        n_cmp++;
        if (InsnCount !== 16'd4) begin
            n_err++; $display("FAIL loop_cnt: got %0d required 4", InsnCount);
        end
    endtask

    task automatic test_halt();
        int ipb;
        apply_reset();
        ipb = ip_cnt;
        prog = '{4'd0, 4'd1};
        Run = 1'b1;
        wait_halted("halt");
        repeat (10) @(negedge Clk);
        n_cmp++;
        if (Halted !== 1'b1 || IpHaltRq !== 1'b1 || Busy !== 1'b0) begin
            n_err++; $display("FAIL halt_hold: Halted=%b IpHaltRq=%b Busy=%b required 1 1 0",
                Halted, IpHaltRq, Busy);
        end
        n_cmp++;
        if (InsnCount !== 16'd1 || ip_cnt - ipb != 2) begin
            n_err++; $display("FAIL halt_cnt: cnt=%0d fetches=%0d required 1 2",
                InsnCount, ip_cnt - ipb);
        end
        Run = 1'b0;
        @(negedge Clk);
        n_cmp++;
        if (Halted !== 1'b0 || IpHaltRq !== 1'b0 || Busy !== 1'b0) begin
            n_err++; $display("FAIL halt_exit: Halted=%b IpHaltRq=%b Busy=%b required 0 0 0",
                Halted, IpHaltRq, Busy);
        end
        Run = 1'b1;
        wait_halted("halt_restart");
        Run = 1'b0;
        @(negedge Clk);
        n_cmp++;
        if (ip_cnt - ipb != 3 || InsnCount !== 16'd1) begin
            n_err++; $display("FAIL halt_restart: fetches=%0d cnt=%0d required 3 1",
                ip_cnt - ipb, InsnCount);
        end
    endtask

    task automatic test_run_drop();
        int base, ipb, k;
        apply_reset();
        base = evt_q.size(); ipb = ip_cnt;
        prog = '{4'd2, 4'd2, 4'd2};
        Run = 1'b1;
        for (k = 0; k < 100 && !DataRequest; k++) @(negedge Clk);
        Run = 1'b0;
        wait_idle("run_drop");
        repeat (10) @(negedge Clk);
        n_cmp++;
        if (InsnCount !== 16'd1 || evt_q.size() - base != 1 || ip_cnt - ipb != 1) begin
            n_err++; $display("FAIL run_drop: cnt=%0d evts=%0d fetches=%0d required 1 1 1",
                InsnCount, evt_q.size() - base, ip_cnt - ipb);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        prog = '{4'd0};
        @(negedge Clk);
        force dut.cnt_q = 16'hFFFF;
        @(negedge Clk);
        release dut.cnt_q;
        n_cmp++;
        if (InsnCount !== 16'hFFFF) begin
            n_err++; $display("FAIL wrap_preload: got %h required ffff", InsnCount);
        end
        pulse_step();
        wait_idle("wrap");
        n_cmp++;
        if (InsnCount !== 16'h0000) begin
            n_err++; $display("FAIL wrap_cnt: got %h required 0000", InsnCount);
        end
    endtask

    task automatic test_io();
        int base, lows, k;
        apply_reset();
        base = evt_q.size(); lows = 0;
        prog = '{4'd8, 4'd9, 4'd1};
        Run = 1'b1;
        for (k = 0; k < 200 && !IoInRequest; k++) @(negedge Clk);
        n_cmp++;
        if (IoInRequest !== 1'b1) begin
            n_err++; $display("FAIL io_in_req timeout: got %b required 1", IoInRequest);
        end
        for (k = 0; k < 10; k++) begin
            @(negedge Clk);
            if (!Busy) lows++;
        end
        wait_halted("io");
        Run = 1'b0;
        @(negedge Clk);
        n_cmp++;
        if (lows != 0) begin
            n_err++; $display("FAIL io_busy: idle cycles=%0d required 0", lows);
        end
        n_cmp++;
        if (evt_q.size() - base != 2 || evt_q[base] != 5 || evt_q[base+1] != 6) begin
            n_err++; $display("FAIL io_evts: count=%0d required 2 events (out, in)",
                evt_q.size() - base);
        end
        n_cmp++;
        if (InsnCount !== 16'd2) begin
            n_err++; $display("FAIL io_cnt: got %0d required 2", InsnCount);
        end
    endtask

    initial begin
        test_reset();
        test_run_program();
        test_step();
        test_loop_flag();
        test_halt();
        test_run_drop();
        test_wrap();
        test_io();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
